// File: rtl/servo_pos_ctrl.sv
// servo_pos_ctrl: debounces the UP/DN/MODO buttons, owns the servo position
// (0..4) and the manual/sweep mode, and generates the servo PWM frame.
module servo_pos_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int PWM_PERIOD  = 1_000_000,
  parameter int PWM_MIN     = 50_000,
  parameter int PWM_STEP    = 12_500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_MODO,
  output logic [2:0] posi,
  output logic       modo,
  output logic       SERVO_PWM
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int PW = $clog2(PWM_PERIOD + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] FRAME_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] MIN_W      = PW'(PWM_MIN);
  localparam logic [PW-1:0] STEP_W     = PW'(PWM_STEP);

  typedef enum logic {MODE_A = 1'b0, MODE_B = 1'b1} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  // Button bit order everywhere: 0 = UP, 1 = DN, 2 = MODO.
  logic [2:0]    btn_raw;
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    deb_level;
  logic [2:0]    deb_prev;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  mode_t         mode;
  dir_t          dir;
  logic [SW-1:0] step_cnt;

  logic [PW-1:0] frame_cnt;
  logic [PW-1:0] width;
  logic [PW-1:0] width_now;

  assign btn_raw = {BTN_MODO, BTN_DN, BTN_UP};

  // A press is the first cycle a debounced level is seen high.
  assign press = deb_level & ~deb_prev;

  assign modo = (mode == MODE_B);

  // Two-flop synchronizers followed by a stable-count debouncer per button.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a    <= '0;
      sync_b    <= '0;
      deb_level <= '0;
      deb_prev  <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      deb_prev <= deb_level;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_level[i] <= sync_b[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Mode/position state machine: MODO wins, then manual steps or the timed sweep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode     <= MODE_A;
      dir      <= DIR_UP;
      step_cnt <= '0;
      posi     <= 3'd0;
    end else if (press[2]) begin
      step_cnt <= '0;
      if (mode == MODE_A) begin
        mode <= MODE_B;
        dir  <= (posi == 3'd4) ? DIR_DOWN : DIR_UP;
      end else begin
        mode <= MODE_A;
      end
    end else if (mode == MODE_A) begin
      step_cnt <= '0;
      if (press[0] && !press[1] && posi != 3'd4) begin
        posi <= posi + 3'd1;
      end else if (press[1] && !press[0] && posi != 3'd0) begin
        posi <= posi - 3'd1;
      end
    end else if (step_cnt == STEP_LAST) begin
      step_cnt <= '0;
      if (dir == DIR_UP) begin
        if (posi == 3'd4) begin
          dir  <= DIR_DOWN;
          posi <= 3'd3;
        end else begin
          posi <= posi + 3'd1;
        end
      end else begin
        if (posi == 3'd0) begin
          dir  <= DIR_UP;
          posi <= 3'd1;
        end else begin
          posi <= posi - 3'd1;
        end
      end
    end else begin
      step_cnt <= step_cnt + SW'(1);
    end
  end

  // The width for a frame is sampled only at its first cycle so pulses never glitch.
  assign width_now = (frame_cnt == '0) ? (MIN_W + PW'(posi) * STEP_W) : width;

  // Frame counter, latched width and registered pulse output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt <= '0;
      width     <= '0;
      SERVO_PWM <= 1'b0;
    end else begin
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + PW'(1);
      width     <= width_now;
      SERVO_PWM <= (frame_cnt < width_now);
    end
  end

endmodule

// File: tb/tb_servo_pos_ctrl.sv
// tb_servo_pos_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a behavioural model of the servo position controller.
module tb_servo_pos_ctrl;

  localparam int DEB    = 4;
  localparam int STEP   = 10;
  localparam int PERIOD = 100;
  localparam int PMIN   = 5;
  localparam int PSTEP  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0;
  logic       BTN_DN = 1'b0;
  logic       BTN_MODO = 1'b0;
  logic [2:0] posi;
  logic       modo;
  logic       SERVO_PWM;

  int compared   = 0;
  int mismatched = 0;

  servo_pos_ctrl #(
    .DEB_CYCLES (DEB),
    .STEP_CYCLES(STEP),
    .PWM_PERIOD (PERIOD),
    .PWM_MIN    (PMIN),
    .PWM_STEP   (PSTEP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_UP   (BTN_UP),
    .BTN_DN   (BTN_DN),
    .BTN_MODO (BTN_MODO),
    .posi     (posi),
    .modo     (modo),
    .SERVO_PWM(SERVO_PWM)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model state ----------------
  int edge_no    = 0;
  int rst_edge   = 0;
  int frame_base = 1;
  int entry_edge = 0;
  int phase      = 0;
  int m_width    = 0;
  int m_posi     = 0;
  bit m_modo     = 1'b0;
  bit m_pwm      = 1'b0;
  bit model_valid = 1'b0;
  int last_clear [3];
  bit raw_hist [3][64];
  bit lvl [3];
  bit pend [3];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input bit md, input bit rst, input int cycles);
    BTN_UP   = up;
    BTN_DN   = dn;
    BTN_MODO = md;
    RST      = rst;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic pressButtons(input bit up, input bit dn, input bit md, input int hold, input int gap);
    applyStimulus(up, dn, md, 1'b0, hold);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, gap);
  endtask

  task automatic waitPwmRise();
    int n;
    n = 0;
    while (SERVO_PWM !== 1'b0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    while (SERVO_PWM !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (SERVO_PWM !== 1'b1) checkOutput("pwm_rise_timeout", 0, 1);
  endtask

  task automatic measureHigh(output int w);
    w = 0;
    while (SERVO_PWM === 1'b1 && w < 200) begin
      w++;
      @(negedge CLK);
    end
  endtask

  // Value the debouncer sees at edge e: the raw level two edges back, zero right after reset.
  function automatic bit syncedAt(int b, int e);
    if (e - 2 <= rst_edge) return 1'b0;
    return raw_hist[b][(e - 2) % 64];
  endfunction

  // Reference model, advanced once per rising edge from the behavioural rules.
  initial begin
    forever begin
      @(posedge CLK);
      begin
        bit raw [3];
        bit flip;
        int fpos;
        edge_no++;
        raw[0] = BTN_UP;
        raw[1] = BTN_DN;
        raw[2] = BTN_MODO;
        for (int b = 0; b < 3; b++) raw_hist[b][edge_no % 64] = raw[b];
        if (RST) begin
          model_valid = 1'b1;
          rst_edge    = edge_no;
          frame_base  = edge_no + 1;
          m_posi      = 0;
          m_modo      = 1'b0;
          m_pwm       = 1'b0;
          for (int b = 0; b < 3; b++) begin
            lvl[b]        = 1'b0;
            pend[b]       = 1'b0;
            last_clear[b] = edge_no;
          end
        end else begin
          fpos = (edge_no - frame_base) % PERIOD;
          if (fpos == 0) m_width = PMIN + m_posi * PSTEP;
          m_pwm = (fpos < m_width);
          if (pend[2]) begin
            m_modo = !m_modo;
            if (m_modo) begin
              entry_edge = edge_no;
              phase      = (m_posi == 4) ? 4 : m_posi;
            end
          end else if (!m_modo) begin
            if (pend[0] && !pend[1]) m_posi = (m_posi < 4) ? m_posi + 1 : 4;
            else if (pend[1] && !pend[0]) m_posi = (m_posi > 0) ? m_posi - 1 : 0;
          end else if ((edge_no - entry_edge) % STEP == 0) begin
            phase  = (phase + 1) % 8;
            m_posi = (phase <= 4) ? phase : 8 - phase;
          end
          for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int i = 0; i < DEB; i++) begin
              if (edge_no - i <= last_clear[b] || syncedAt(b, edge_no - i) == lvl[b]) flip = 1'b0;
            end
            pend[b] = 1'b0;
            if (flip) begin
              lvl[b]        = !lvl[b];
              last_clear[b] = edge_no;
              pend[b]       = lvl[b];
            end
          end
        end
      end
    end
  end

  // Every falling edge compares all outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (model_valid) begin
        checkOutput("cyc_posi", int'(posi), m_posi);
        checkOutput("cyc_modo", int'(modo), int'(m_modo));
        checkOutput("cyc_pwm", int'(SERVO_PWM), int'(m_pwm));
      end
    end
  end

  // Hard stop in case anything stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, mismatches so far %0d", mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by random traffic.
  initial begin
    int hi_count;
    int lead;
    int w1;
    int w2;
    int frozen;
    int up_seq [6];
    int dn_seq [6];
    int sweep_exp [6];
    bit r;
    up_seq    = '{1, 2, 3, 4, 4, 4};
    dn_seq    = '{3, 2, 1, 0, 0, 0};
    sweep_exp = '{4, 3, 2, 1, 0, 1};

    $display("[TB] reset");
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 3);
    checkOutput("rst_posi", int'(posi), 0);
    checkOutput("rst_modo", int'(modo), 0);
    checkOutput("rst_pwm", int'(SERVO_PWM), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
    hi_count = 0;
    lead = -1;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge CLK);
      if (SERVO_PWM === 1'b1) hi_count++;
      else if (lead < 0) lead = i;
    end
    checkOutput("first_frame_high", hi_count, 5);
    checkOutput("first_frame_lead", lead, 5);

    $display("[TB] debounce");
    pressButtons(1'b1, 1'b0, 1'b0, 3, 15);
    checkOutput("glitch_ignored", int'(posi), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6);
    checkOutput("deb_early", int'(posi), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("deb_latency", int'(posi), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 15);
    checkOutput("release_no_event", int'(posi), 1);

    $display("[TB] saturation");
    pressButtons(1'b0, 1'b1, 1'b0, 6, 8);
    checkOutput("back_to_zero", int'(posi), 0);
    for (int k = 0; k < 6; k++) begin
      pressButtons(1'b1, 1'b0, 1'b0, 6, 8);
      checkOutput("up_sat", int'(posi), up_seq[k]);
    end
    waitPwmRise();
    measureHigh(w1);
    checkOutput("pulse_pos4", w1, 13);
    for (int k = 0; k < 6; k++) begin
      pressButtons(1'b0, 1'b1, 1'b0, 6, 8);
      checkOutput("dn_sat", int'(posi), dn_seq[k]);
    end

    $display("[TB] sweep");
    repeat (3) pressButtons(1'b1, 1'b0, 1'b0, 6, 8);
    checkOutput("pre_sweep_posi", int'(posi), 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7);
    checkOutput("modo_on", int'(modo), 1);
    checkOutput("modo_on_posi", int'(posi), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, STEP);
      checkOutput("sweep_step", int'(posi), sweep_exp[k]);
    end
    repeat (3) pressButtons(1'b1, 1'b0, 1'b0, 6, 8);
    checkOutput("sweep_still_b", int'(modo), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7);
    checkOutput("modo_off", int'(modo), 0);
    frozen = m_posi;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 30);
    checkOutput("posi_frozen", int'(posi), frozen);

    $display("[TB] simultaneous and mid-frame");
    repeat (5) pressButtons(1'b0, 1'b1, 1'b0, 6, 8);
    repeat (2) pressButtons(1'b1, 1'b0, 1'b0, 6, 8);
    checkOutput("posi_two", int'(posi), 2);
    pressButtons(1'b1, 1'b1, 1'b0, 6, 8);
    checkOutput("simul_updn", int'(posi), 2);
    repeat (2) pressButtons(1'b0, 1'b1, 1'b0, 6, 8);
    checkOutput("posi_zero", int'(posi), 0);
    waitPwmRise();
    fork
      measureHigh(w1);
      begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);
        repeat (4) pressButtons(1'b1, 1'b0, 1'b0, 6, 6);
      end
    join
    checkOutput("midframe_cur", w1, 5);
    checkOutput("midframe_posi", int'(posi), 4);
    waitPwmRise();
    measureHigh(w2);
    checkOutput("midframe_next", w2, 13);

    $display("[TB] reset mid-operation");
    repeat (2) pressButtons(1'b0, 1'b1, 1'b0, 6, 8);
    checkOutput("pre_rst_posi_a", int'(posi), 2);
    waitPwmRise();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, PERIOD - 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7);
    checkOutput("pre_rst_modo", int'(modo), 1);
    checkOutput("pre_rst_posi", int'(posi), 2);
    checkOutput("pre_rst_pwm", int'(SERVO_PWM), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("midrst_posi", int'(posi), 0);
    checkOutput("midrst_modo", int'(modo), 0);
    checkOutput("midrst_pwm", int'(SERVO_PWM), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("frame_restart", int'(SERVO_PWM), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);
    checkOutput("post_rst_modo", int'(modo), 0);
    checkOutput("post_rst_posi", int'(posi), 0);

    $display("[TB] random traffic");
    for (int s = 0; s < 200; s++) begin
      r = ($urandom_range(0, 29) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), r,
                    r ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 16)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/servo_pos_ctrl.md
Name: servo_pos_ctrl

Overview:
Upstream control stage of the servo board. It debounces three raw push-buttons and owns the servo position state, `posi` (0..4), and the operating mode, `modo` (A = manual, B = automatic sweep). It drives both the display stage's `posi`/`modo` inputs and the servo PWM line. It runs entirely in the 50 MHz `CLK` domain.

Parameters:
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level (20 ms).
- STEP_CYCLES, 50_000_000: cycles between automatic steps in mode B (1 s).
- PWM_PERIOD, 1_000_000: servo frame length in cycles (20 ms).
- PWM_MIN, 50_000: pulse width for posi=0 in cycles (1 ms).
- PWM_STEP, 12_500: added pulse width per posi increment (0.25 ms).

Ports:
- CLK, input, 1: system clock, 50 MHz.
- RST, input, 1: synchronous, active-high reset.
- BTN_UP, input, 1: raw asynchronous button; pressed = 1.
- BTN_DN, input, 1: raw asynchronous button; pressed = 1.
- BTN_MODO, input, 1: raw asynchronous button; pressed = 1.
- posi, output, 3: current position 0..4; values 5..7 are never driven.
- modo, output, 1: 0 = mode A (manual), 1 = mode B (sweep).
- SERVO_PWM, output, 1: servo control pulse.

Behaviour:
- Reset and clocking:
  - One clock, `CLK`; reset is synchronous and active-high (`RST`).
  - While `RST`=1, all state clears at the clock edge: `posi`=0, `modo`=0, `SERVO_PWM`=0, sweep direction=up, all counters=0, debounced levels=0, sync flops=0.
  - Reset asserted mid-operation (mid-pulse, mid-debounce, mid-sweep) aborts everything. `SERVO_PWM` is 0 on the first edge with `RST` high, and a new frame starts at the first edge after `RST` falls.
- Input conditioning, per button:
  - Two-flop synchronizer.
  - Debounce counter: reset to 0 whenever the synchronized value equals the debounced level; incremented otherwise.
  - When the counter reaches DEB_CYCLES-1 and the values still differ, the debounced level takes the new value and the counter clears.
  - Press event: a one-cycle pulse on a debounced 0->1 transition. Releases generate no event.
  - Latency: raw edge held stable -> `posi`/`modo` updated exactly DEB_CYCLES+3 cycles later.
  - Glitches shorter than DEB_CYCLES never produce an event.
- Mode A (`modo`=0):
  - UP event: `posi`+1, saturating at 4.
  - DN event: `posi`-1, saturating at 0.
  - UP and DN events in the same cycle: no change.
- Mode B (`modo`=1):
  - UP/DN events are ignored.
  - The step counter counts 0..STEP_CYCLES-1. At its terminal count `posi` moves one step in the sweep direction.
  - Ping-pong sweep: at `posi`=4 with direction up, direction flips to down and `posi` becomes 3. The mirror case applies at 0.
  - Sequence from 0: 0,1,2,3,4,3,2,1,0,1...
- MODO event:
  - Toggles `modo` in the cycle after the event pulse. Takes priority over any UP/DN/step event in the same cycle; `posi` does not move in that cycle.
  - Entering B: step counter clears. Direction = down if `posi`=4, else up. The first automatic step occurs STEP_CYCLES cycles after the toggle.
  - Entering A: `posi` holds its current value; the step counter is held at 0.
- PWM:
  - Frame counter runs 0..PWM_PERIOD-1 and wraps.
  - At frame counter 0, the width register latches PWM_MIN + `posi`*PWM_STEP. Arithmetic is unsigned, with width ≥ clog2(PWM_PERIOD).
  - `SERVO_PWM` is registered: high while frame counter < latched width, low otherwise.
  - A `posi` change mid-frame affects only the next frame; this is required for glitch-free pulses.
  - The output is delayed 1 cycle relative to the counter compare.
- Constraint: PWM_MIN + 4*PWM_STEP < PWM_PERIOD is required. No overflow handling is provided.

Test Plan (bench parameters DEB_CYCLES=4, STEP_CYCLES=10, PWM_PERIOD=100, PWM_MIN=5, PWM_STEP=2):
1. Reset:
   - Stimulus: hold `RST` 3 cycles with random buttons.
   - Required: `posi`=0, `modo`=0, `SERVO_PWM`=0. First frame after release is high for exactly 5 cycles, then low for 95.
2. Debounce:
   - Stimulus: pulse BTN_UP for 3 cycles.
   - Required: `posi` stays 0.
   - Stimulus: hold BTN_UP for 20 cycles.
   - Required: `posi`=1 exactly 7 cycles after the raw edge. Releasing gives no change.
3. Saturation:
   - Stimulus: 6 clean UP presses.
   - Required: `posi` sequence 1,2,3,4,4,4; next frame high for 13 cycles.
   - Stimulus: 6 DN presses.
   - Required: `posi` reaches 0 and holds.
4. Sweep:
   - Stimulus: from `posi`=3, press MODO.
   - Required: `modo`=1; `posi` steps 4,3,2,1,0,1 every 10 cycles.
   - Stimulus: UP presses during the sweep.
   - Required: they are ignored.
   - Stimulus: press MODO again.
   - Required: `modo`=0 and `posi` frozen.
5. Simultaneous and mid-frame events:
   - Stimulus: UP and DN debounced on the same cycle.
   - Required: `posi` unchanged.
   - Stimulus: `posi` 0->4 at frame counter 50.
   - Required: the current frame pulse stays 5 cycles; the next frame pulse is 13 cycles.
6. Reset mid-operation:
   - Stimulus: assert `RST` during mode B with `posi`=2 and `SERVO_PWM` high.
   - Required: all outputs 0 on the next edge; after release, mode A with `posi`=0.
